// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS fetch constants, queue entry type and PC helper
package mips_defs_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] MIPS_NOP_WORD = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] MIPS_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] pc_next(input logic [INSTR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order prefetch FIFO of {PC+4, instruction} with flush
module fetch_queue
    import mips_defs_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output logic [$clog2(QDEPTH+1)-1:0]  count_o,
    output fetch_entry_t                 head_o
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(QDEPTH - 1);

    fetch_entry_t  mem_q [QDEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(QDEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC, credit-limited imem requests, prefetch queue, redirect
module if_fetch_stage
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_WORD = MIPS_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    output logic [31:0] PC_OUT,
    output logic [31:0] IR_OUT,
    output logic        Valid_OUT
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW+1)'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] q_count;
    logic [CW:0]   occupancy;
    logic          issue, drop, push, pop;
    fetch_entry_t  head, push_entry;

    // rsp_pc_q is PC+4 of the next kept response: kept responses are always sequential
    // because only a redirect breaks the stream, and a redirect discards everything older.
    always_comb begin
        Valid_OUT  = (q_count != '0) && !Redirect;
        pop        = Valid_OUT && !Stall;
        drop       = Imem_Rvalid && (discard_q != '0);
        push       = Imem_Rvalid && !drop && !Redirect;
        occupancy  = {1'b0, inflight_q} + {1'b0, q_count} - {{CW{1'b0}}, pop};
        Imem_Req   = !Rst && !Redirect && (occupancy < CREDITS);
        issue      = Imem_Req && Imem_Gnt;
        Imem_Addr  = pc_q;
        PC_OUT     = Valid_OUT ? head.pc_plus4 : 32'h0;
        IR_OUT     = Valid_OUT ? head.instr : NOP_WORD;
        push_entry.pc_plus4 = rsp_pc_q;
        push_entry.instr    = Imem_Rdata;

        inflight_d = inflight_q + CW'(issue) - CW'(Imem_Rvalid);
        if (Redirect) begin
            pc_d      = Redirect_PC;
            rsp_pc_d  = pc_next(Redirect_PC);
            discard_d = inflight_q - CW'(Imem_Rvalid);
        end else begin
            pc_d      = issue ? pc_next(pc_q) : pc_q;
            rsp_pc_d  = push ? pc_next(rsp_pc_q) : rsp_pc_q;
            discard_d = discard_q - CW'(drop);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= pc_next(RESET_PC);
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .flush_i     (Redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (q_count),
        .head_o      (head)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Redirect;
    logic [31:0] Redirect_PC;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Gnt, Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic [31:0] PC_OUT, IR_OUT;
    logic        Valid_OUT;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    if_fetch_stage dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .Imem_Gnt    (Imem_Gnt),
        .Imem_Rvalid (Imem_Rvalid),
        .Imem_Rdata  (Imem_Rdata),
        .PC_OUT      (PC_OUT),
        .IR_OUT      (IR_OUT),
        .Valid_OUT   (Valid_OUT)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the in-order memory model records issues and presents due responses.
    task automatic cycle();
        logic        iss, rsp;
        logic [31:0] a;
        iss = Imem_Req && Imem_Gnt;
        rsp = Imem_Rvalid;
        a   = Imem_Addr;
        @(posedge Clk);
        #1;
        cyc++;
        if (Rst) begin
            pend_addr.delete();
            pend_due.delete();
        end else begin
            if (rsp) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (iss) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc - 1 + lat);
            end
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            Imem_Rvalid = 1'b1;
            Imem_Rdata  = pend_addr[0] | 32'hA000_0000;
        end else begin
            Imem_Rvalid = 1'b0;
            Imem_Rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic rst_seq();
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Imem_Gnt = 1'b1; lat = 1;
        cycle();
        Rst = 1'b0;
        #1;
    endtask

    initial begin
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'h0;
        Imem_Gnt = 1'b1; Imem_Rvalid = 1'b0; Imem_Rdata = 32'h0;
        cycle();
        cycle();
        chk("rst_req", Imem_Req, 1'b0);
        chk("rst_valid", Valid_OUT, 1'b0);
        chk("rst_ir", IR_OUT, 32'h0);
        chk("rst_pcout", PC_OUT, 32'h0);
        Rst = 1'b0;
        #1;

        // Zero-wait stream
        chk("t1_c0_req", Imem_Req, 1'b1);
        chk("t1_c0_addr", Imem_Addr, 32'h0);
        chk("t1_c0_valid", Valid_OUT, 1'b0);
        cycle();
        chk("t1_c1_valid", Valid_OUT, 1'b0);
        chk("t1_c1_addr", Imem_Addr, 32'h4);
        cycle();
        chk("t1_c2_valid", Valid_OUT, 1'b1);
        chk("t1_c2_pc", PC_OUT, 32'h4);
        chk("t1_c2_ir", IR_OUT, 32'hA000_0000);
        cycle();

        // Stall three cycles at PC_OUT=8
        Stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_valid", Valid_OUT, 1'b1);
            chk("t2_stall_pc", PC_OUT, 32'h8);
            chk("t2_stall_ir", IR_OUT, 32'hA000_0004);
            chk("t2_stall_req", Imem_Req, 1'b0);
            cycle();
        end
        Stall = 1'b0;
        #1;
        chk("t2_rel_pc8", PC_OUT, 32'h8);
        chk("t2_rel_req", Imem_Req, 1'b1);
        chk("t2_rel_addr", Imem_Addr, 32'hC);
        cycle();
        chk("t2_pcC", PC_OUT, 32'hC);
        chk("t2_irC", IR_OUT, 32'hA000_0008);
        cycle();
        chk("t2_pc10", PC_OUT, 32'h10);
        chk("t2_ir10", IR_OUT, 32'hA000_000C);
        chk("t2_v10", Valid_OUT, 1'b1);

        // Reset mid-stream
        Rst = 1'b1;
        #1;
        chk("t6_rst_req", Imem_Req, 1'b0);
        cycle();
        chk("t6_rst_addr", Imem_Addr, 32'h0);
        chk("t6_rst_valid", Valid_OUT, 1'b0);
        Rst = 1'b0;
        #1;

        // Redirect with two slow requests in flight
        lat = 3;
        chk("t3_c0_addr", Imem_Addr, 32'h0);
        cycle();
        chk("t3_c1_addr", Imem_Addr, 32'h4);
        cycle();
        Redirect = 1'b1; Redirect_PC = 32'h400;
        #1;
        chk("t3_redir_req", Imem_Req, 1'b0);
        chk("t3_redir_valid", Valid_OUT, 1'b0);
        cycle();
        Redirect = 1'b0;
        #1;
        chk("t3_c3_addr", Imem_Addr, 32'h400);
        chk("t3_c3_req", Imem_Req, 1'b0);
        for (int i = 3; i < 8; i++) begin
            chk("t3_stale_valid", Valid_OUT, 1'b0);
            if (i == 4) chk("t3_c4_req", Imem_Req, 1'b1);
            cycle();
        end
        chk("t3_valid", Valid_OUT, 1'b1);
        chk("t3_pc", PC_OUT, 32'h404);
        chk("t3_ir", IR_OUT, 32'hA000_0400);

        // Grant withheld four cycles
        rst_seq();
        Imem_Gnt = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", Imem_Req, 1'b1);
            chk("t4_addr", Imem_Addr, 32'h0);
            chk("t4_valid", Valid_OUT, 1'b0);
            chk("t4_ir", IR_OUT, 32'h0);
            cycle();
        end
        Imem_Gnt = 1'b1;
        #1;
        chk("t4_gnt_addr", Imem_Addr, 32'h0);
        cycle();
        chk("t4_next_addr", Imem_Addr, 32'h4);
        chk("t4_next_valid", Valid_OUT, 1'b0);
        cycle();
        chk("t4_valid", Valid_OUT, 1'b1);
        chk("t4_pc", PC_OUT, 32'h4);

        // Redirect + Stall + Rvalid together
        rst_seq();
        cycle();
        cycle();
        Redirect = 1'b1; Stall = 1'b1; Redirect_PC = 32'h800;
        #1;
        chk("t5_rvalid_present", Imem_Rvalid, 1'b1);
        chk("t5_valid", Valid_OUT, 1'b0);
        chk("t5_pc", PC_OUT, 32'h0);
        chk("t5_ir", IR_OUT, 32'h0);
        chk("t5_req", Imem_Req, 1'b0);
        cycle();
        Redirect = 1'b0; Stall = 1'b0;
        #1;
        chk("t5_next_valid", Valid_OUT, 1'b0);
        chk("t5_next_addr", Imem_Addr, 32'h800);
        chk("t5_next_req", Imem_Req, 1'b1);
        cycle();
        cycle();
        chk("t5_tgt_valid", Valid_OUT, 1'b1);
        chk("t5_tgt_pc", PC_OUT, 32'h804);
        chk("t5_tgt_ir", IR_OUT, 32'hA000_0800);

        // PC wrap at top of address space
        rst_seq();
        Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
        #1;
        chk("t6_redir_req", Imem_Req, 1'b0);
        cycle();
        Redirect = 1'b0;
        #1;
        chk("t6_top_addr", Imem_Addr, 32'hFFFF_FFFC);
        chk("t6_top_req", Imem_Req, 1'b1);
        cycle();
        chk("t6_wrap_addr", Imem_Addr, 32'h0);
        cycle();
        chk("t6_wrap_valid", Valid_OUT, 1'b1);
        chk("t6_wrap_pc", PC_OUT, 32'h0);
        chk("t6_wrap_ir", IR_OUT, 32'hFFFF_FFFC);
        Rst = 1'b1;
        #1;
        chk("t6_mid_req", Imem_Req, 1'b0);
        cycle();
        chk("t6_mid_addr", Imem_Addr, 32'h0);
        chk("t6_mid_valid", Valid_OUT, 1'b0);
        Rst = 1'b0;
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
